imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: takes a framed byte stream (boot UART or debug port) and writes 32-bit instruction words into InstructionMemory.
- While it writes, it holds the CPU in reset through cpu_hold. The IF stage's PC is reset to 0, so after release the CPU fetches from the freshly loaded image.
- Frame format: magic 0xA5, word count (16-bit, little-endian), count×4 payload bytes (little-endian words), then a 1-byte checksum equal to the XOR of all payload bytes.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- MAX_WORDS, 1024, largest word count accepted. Larger counts are an error.
- TIMEOUT_CYCLES, 1_000_000, maximum gap in cycles between accepted bytes once a frame has started.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_req  input  1  single-cycle pulse that starts a load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- imem_we  output  1  single-cycle write strobe.
- imem_addr  output  32  word-aligned byte address.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  CPU reset request, active-high.
- done  output  1  sticky load-success flag.
- error  output  1  sticky load-failure flag.

Behaviour:
- Reset is asynchronous and active-low on `reset`; one clock, `clk`. All state registers clear on assertion.
- Outputs while reset is asserted: state=IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=0, done=0, error=0.
- States: IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. All outputs are registered except in_ready, which decodes from state.
- IDLE / DONE / ERR:
  - in_ready=0.
  - load_req → SYNC. Set cpu_hold=1; clear done, error, checksum, word index and byte counter.
- SYNC:
  - in_ready=1.
  - Byte 0xA5 → LEN_LO. Any other byte is discarded and the block stays in SYNC.
  - No timeout applies in SYNC.
- LEN_LO: capture count[7:0] → LEN_HI.
- LEN_HI: capture count[15:8], then:
  - count > MAX_WORDS → ERR.
  - count == 0 → CSUM.
  - otherwise → DATA.
- DATA:
  - Bytes are packed little-endian: byte0 → [7:0] … byte3 → [31:24]. Each byte is XORed into the checksum.
  - On acceptance of byte3: the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4×word_index and imem_wdata = the packed word. word_index then increments. Write latency is 1 cycle after the 4th byte handshake.
  - After the last word's byte3 → CSUM. The final write strobe may coincide with the first CSUM cycle.
- CSUM (one byte):
  - Byte equals checksum → DONE. Set done=1 and drop cpu_hold to 0 in the same cycle done rises.
  - Byte differs → ERR. Set error=1; cpu_hold stays 1.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CSUM, a counter runs on every cycle with no accepted byte and clears on each handshake.
  - Reaching TIMEOUT_CYCLES → ERR.
- load_req handling:
  - Ignored in SYNC through CSUM; no restart mid-frame.
  - In DONE or ERR it restarts the load. done/error clear and cpu_hold rises on the next edge.
- Reset mid-frame:
  - Abandons the load immediately. cpu_hold=0, and no imem_we is issued after reset.
  - Words already written stay in memory; no rollback.
- Address arithmetic: 32-bit modulo wrap; no check against memory size beyond MAX_WORDS.
- imem_we is never asserted outside DATA, or on the cycle right after DATA→CSUM for the final word.

Decomposition:
- Shared package riscv_pkg:
  - loader_state_e, a 3-bit enum of the eight states.
  - Constant LOADER_MAGIC = 8'hA5.
- Sub-module loader_byte_packer holds the 2-bit byte counter and the 32-bit shift/assembly register. It has one output, word_valid, which pulses for one cycle when a word is complete. imem_loader owns the FSM, the counters, the checksum and the write port.

Test Plan:
- Two-word load: load_req; bytes A5 02 00 | 13 05 10 00 | 93 05 20 00 | csum = XOR of the 8 payload bytes.
  - Required: imem_we at addr 0 with 0x00100513, then addr 4 with 0x00200593.
  - Then done=1, cpu_hold 1→0, error=0.
- Garbage before sync: bytes 00 FF 5A, then a valid frame with count=1.
  - Required: the three leading bytes are consumed with no effect; exactly one write of the payload word.
- Bad checksum: count=1 frame with checksum byte XORed with 0x01.
  - Required: the write still occurs, then error=1, cpu_hold stays 1, done=0.
  - A following load_req then clears error.
- Limits: count=0 with checksum 00 → done=1 with no imem_we. count=MAX_WORDS+1 → error=1 right after the LEN_HI byte, with no writes.
- Timeout and reset:
  - With TIMEOUT_CYCLES=16, stop the stream after LEN_HI → error=1 after 16 idle cycles.
  - Separately, assert reset during DATA → all outputs go to reset values asynchronously, and there is no write after release.
- Backpressure and mid-frame load_req: hold in_valid low for random gaps within the timeout limit, and pulse load_req during DATA.
  - Required: the data written is identical to the gap-free run, and load_req has no effect.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader.
// Provides the loader FSM state encoding, the frame magic byte, common
// datapath widths and small state-decode helpers used by imem_loader.
package riscv_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 16;

  localparam logic [BYTE_W-1:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_e;

  // States after the magic byte, where the inter-byte timeout is armed.
  function automatic logic loader_in_frame(input loader_state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

  // States in which the byte stream is consumed.
  function automatic logic loader_accepts(input loader_state_e s);
    return (s == ST_SYNC) || loader_in_frame(s);
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   clear           restart assembly at byte 0 (start of a new load)
//   byte_valid      a payload byte is accepted this cycle
//   byte_data       the payload byte
//   word_valid      one-cycle pulse, the cycle after the 4th byte is accepted
//   word            the assembled word, held until the next completion
module loader_byte_packer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned HOLD_W = WORD_W - BYTE_W;

  logic [1:0]        cnt, cnt_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [WORD_W-1:0] word_n;
  logic              word_valid_n;

  // Byte slotting; the 4th byte bypasses the holding register into the word.
  always_comb begin
    cnt_n        = cnt;
    hold_n       = hold;
    word_n       = word;
    word_valid_n = 1'b0;
    if (clear) begin
      cnt_n  = 2'd0;
      hold_n = '0;
    end else if (byte_valid) begin
      cnt_n = cnt + 2'd1;
      case (cnt)
        2'd0: hold_n[7:0]   = byte_data;
        2'd1: hold_n[15:8]  = byte_data;
        2'd2: hold_n[23:16] = byte_data;
        default: begin
          word_n       = {byte_data, hold};
          word_valid_n = 1'b1;
        end
      endcase
    end
  end

  // Packer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 2'd0;
      hold       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      hold       <= hold_n;
      word       <= word_n;
      word_valid <= word_valid_n;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream
// (A5, count16 LE, count x 4 payload bytes LE, XOR checksum) and writes the
// payload words into instruction memory while holding the CPU in reset.
// Ports:
//   clk, reset             clock and asynchronous active-low reset
//   load_req               pulse that starts a load (IDLE/DONE/ERR only)
//   in_valid/in_data       byte stream, accepted when in_valid && in_ready
//   in_ready               decoded from state
//   imem_we/addr/wdata     registered write port, one strobe per word
//   cpu_hold               CPU reset request while a load is in progress
//   done/error             sticky load result flags
module imem_loader
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LEFT_W  = COUNT_W + 2;

  loader_state_e      state, state_n;
  logic [BYTE_W-1:0]  count_lo, count_lo_n;
  logic [LEFT_W-1:0]  bytes_left, bytes_left_n;
  logic [BYTE_W-1:0]  csum, csum_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [WORD_W-1:0]  addr_n;
  logic               cpu_hold_n, done_n, error_n;
  logic               pack_clear, pack_valid;
  logic               word_valid;
  logic [WORD_W-1:0]  word;
  logic               hs;
  logic [COUNT_W-1:0] count_full;

  assign in_ready   = loader_accepts(state);
  assign hs         = in_valid && in_ready;
  assign count_full = {in_data, count_lo};

  // The packer's registered strobe and word form the write port directly,
  // giving one cycle from the 4th byte handshake to imem_we.
  assign imem_we    = word_valid;
  assign imem_wdata = word;

  loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state, datapath and flag logic.
  always_comb begin
    state_n      = state;
    count_lo_n   = count_lo;
    bytes_left_n = bytes_left;
    csum_n       = csum;
    timer_n      = timer;
    addr_n       = imem_addr;
    cpu_hold_n   = cpu_hold;
    done_n       = done;
    error_n      = error;
    pack_clear   = 1'b0;
    pack_valid   = 1'b0;

    // imem_addr always points at the word being (or next to be) written.
    if (word_valid) begin
      addr_n = imem_addr + 32'd4;
    end

    // Inter-byte gap counter, only armed once the magic byte is seen.
    if (loader_in_frame(state)) begin
      timer_n = hs ? '0 : timer + TIMER_W'(1);
    end

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_req) begin
          state_n      = ST_SYNC;
          cpu_hold_n   = 1'b1;
          done_n       = 1'b0;
          error_n      = 1'b0;
          csum_n       = '0;
          count_lo_n   = '0;
          bytes_left_n = '0;
          timer_n      = '0;
          addr_n       = BASE_ADDR;
          pack_clear   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (hs && (in_data == LOADER_MAGIC)) begin
          state_n = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (hs) begin
          count_lo_n = in_data;
          state_n    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (hs) begin
          if (32'(count_full) > MAX_WORDS) begin
            state_n = ST_ERR;
            error_n = 1'b1;
          end else if (count_full == '0) begin
            state_n = ST_CSUM;
          end else begin
            bytes_left_n = {count_full, 2'b00};
            state_n      = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          pack_valid   = 1'b1;
          csum_n       = csum ^ in_data;
          bytes_left_n = bytes_left - LEFT_W'(1);
          if (bytes_left == LEFT_W'(1)) begin
            state_n = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          if (in_data == csum) begin
            state_n    = ST_DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else begin
            state_n = ST_ERR;
            error_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Gap limit reached with no byte this cycle aborts the frame.
    if (loader_in_frame(state) && !hs && (timer == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
      state_n = ST_ERR;
      error_n = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count_lo   <= '0;
      bytes_left <= '0;
      csum       <= '0;
      timer      <= '0;
      imem_addr  <= BASE_ADDR;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      count_lo   <= count_lo_n;
      bytes_left <= bytes_left_n;
      csum       <= csum_n;
      timer      <= timer_n;
      imem_addr  <= addr_n;
      cpu_hold   <= cpu_hold_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued when a
// frame is issued and a monitor compares every imem_we strobe against them.
module tb_imem_loader;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR      (32'h0000_0000),
    .MAX_WORDS      (1024),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e.addr);
          check("wr_data", imem_wdata, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Present one byte, wait (bounded) for acceptance, then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL byte_accept: in_ready low for %0d cycles, required high", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int pick_gap(input int gap_max);
    if (gap_max == 0) return 0;
    return int'($urandom_range(32'(gap_max), 0));
  endfunction

  // Full frame from frame_words with a hand-computed checksum byte.
  task automatic send_frame(input logic [15:0] count, input logic [7:0] csum,
                            input int gap_max, input bit mid_load);
    logic [31:0] w;
    send_byte(LOADER_MAGIC, pick_gap(gap_max));
    send_byte(count[7:0], pick_gap(gap_max));
    send_byte(count[15:8], pick_gap(gap_max));
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      exp_q.push_back('{addr: 32'(i * 4), data: w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], pick_gap(gap_max));
        if (mid_load && i == 0 && k == 1) begin
          pulse_load();
          check("midload_hold", 32'(cpu_hold), 32'd1);
        end
      end
    end
    send_byte(csum, pick_gap(gap_max));
  endtask

  initial begin
    reset    = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Two-word load.
    pulse_load();
    check("t1_hold_up", 32'(cpu_hold), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    frame_words = '{32'h0010_0513, 32'h0020_0593};
    send_frame(16'd2, 8'hB0, 0, 1'b0);
    idle(2);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_error", 32'(error), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Garbage before sync.
    pulse_load();
    check("t2_done_clr", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    frame_words = '{32'hDEAD_BEEF};
    send_frame(16'd1, 8'h22, 0, 1'b0);
    idle(2);
    check("t2_done", 32'(done), 32'd1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Bad checksum (true value 08).
    pulse_load();
    frame_words = '{32'h1234_5678};
    send_frame(16'd1, 8'h09, 0, 1'b0);
    idle(2);
    check("t3_error", 32'(error), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    pulse_load();
    check("t3_error_clr", 32'(error), 32'd0);
    check("t3_hold_again", 32'(cpu_hold), 32'd1);

    // Zero-word frame (already in SYNC).
    frame_words = {};
    send_frame(16'd0, 8'h00, 0, 1'b0);
    idle(2);
    check("t4_done", 32'(done), 32'd1);
    check("t4_error", 32'(error), 32'd0);
    check("t4_hold", 32'(cpu_hold), 32'd0);

    // Count of MAX_WORDS+1 = 0x0401.
    pulse_load();
    send_byte(LOADER_MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("t5_error", 32'(error), 32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd1);
    idle(4);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Timeout after LEN_HI: error exactly on the 16th idle cycle.
    pulse_load();
    send_byte(LOADER_MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    idle(15);
    check("t6_not_yet", 32'(error), 32'd0);
    idle(1);
    check("t6_timeout", 32'(error), 32'd1);
    check("t6_in_ready", 32'(in_ready), 32'd0);

    // Reset during DATA: first word written, second abandoned.
    pulse_load();
    send_byte(LOADER_MAGIC, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 reset = 1'b0;
    #1;
    check("t7_in_ready", 32'(in_ready), 32'd0);
    check("t7_we", 32'(imem_we), 32'd0);
    check("t7_addr", imem_addr, 32'h0);
    check("t7_wdata", imem_wdata, 32'h0);
    check("t7_hold", 32'(cpu_hold), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_error", 32'(error), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(10);
    check("t7_drained", 32'(exp_q.size()), 32'd0);
    check("t7_hold_after", 32'(cpu_hold), 32'd0);

    // Gapped stream with a load_req pulse during DATA.
    pulse_load();
    frame_words = '{32'h0000_0013, 32'h0050_0093, 32'hFFF0_0113};
    send_frame(16'd3, 8'hCD, 10, 1'b1);
    idle(2);
    check("t8_done", 32'(done), 32'd1);
    check("t8_error", 32'(error), 32'd0);
    check("t8_hold", 32'(cpu_hold), 32'd0);
    check("t8_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
